// File: rtl/and_rr_arbiter.sv
// Round-robin arbiter that shares one AND unit among NUM_REQ valid/ready requesters.
// Optional feature macro: AND_ARB_STALL_CNT_EN adds a saturating stall_cnt output.

module and_unit #(
  parameter int W = 3
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

module and_rr_arbiter #(
  parameter  int REG_WIDTH = 3,
  parameter  int NUM_REQ   = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*REG_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*REG_WIDTH-1:0] req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [REG_WIDTH-1:0]         rsp_data,
`ifdef AND_ARB_STALL_CNT_EN
  output logic [ID_W-1:0]              rsp_id,
  output logic [15:0]                  stall_cnt
`else
  output logic [ID_W-1:0]              rsp_id
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]      win_idx;
  logic                 win_found;
  logic                 can_accept;
  logic                 accept;
  logic [REG_WIDTH-1:0] a_sel, b_sel, and_y;

  // Rotating search starting one past the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  assign can_accept = (state_q == IDLE) || (rsp_ready && (state_q == RESP));
  assign accept     = win_found && can_accept && !rst;
  assign a_sel      = req_a[int'(win_idx)*REG_WIDTH +: REG_WIDTH];
  assign b_sel      = req_b[int'(win_idx)*REG_WIDTH +: REG_WIDTH];

  and_unit #(.W(REG_WIDTH)) u_and (
    .a_i (a_sel),
    .b_i (b_sel),
    .y_o (and_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? RESP : IDLE;
      RESP: begin
        if (accept)         state_d = RESP;
        else if (rsp_ready) state_d = IDLE;
        else                state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result and grant pointer load only on accept; held otherwise.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    if (accept) begin
      last_grant_d = win_idx;
      rsp_data_d   = and_y;
      rsp_id_d     = win_idx;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
    rsp_valid = (state_q == RESP);
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
  end

`ifdef AND_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if ((state_q == RESP) && !rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
